mem_access: RTL and testbench

Memory-access stage sitting directly downstream of the executer. It consumes the executer's ALU result and its forwarded memory and register controls, and performs byte/half/word loads and stores over a req/ack data-memory port with lane alignment and sign extension. It then presents a single-cycle writeback beat (rd, data, we) to the register-file writeback stage, and raises `busy` to stall upstream while a memory transaction is outstanding.

---
 rtl/mspu_pkg.sv | 16 +
 rtl/mem_access_lsu_align.sv | 51 +++++
 rtl/mem_access.sv | 157 +++++++++++++++
 tb/tb_mem_access.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mspu_pkg.sv
// Shared types for the memory-access stage: access sizes and FSM states.
package mspu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_lsu_align.sv
// Lane steering for the memory-access stage: byte enables, store replication,
// load shift with sign/zero extension, and the misalignment flag.
module lsu_align
    import mspu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  bytes,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] rdata_sh;

    assign rdata_sh = rdata >> {addr_lo, 3'b000};

    // Decode size into lanes, replicated store data, extended load value and alignment.
    always_comb begin
        be        = 4'h0;
        wdata_rep = wdata;
        load_data = rdata_sh;
        misalign  = 1'b0;
        case (size_e'(bytes))
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_data = load_unsigned ? {24'h0, rdata_sh[7:0]}
                                          : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                load_data = load_unsigned ? {16'h0, rdata_sh[15:0]}
                                          : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
                misalign  = addr_lo[0];
            end
            SZ_WORD: begin
                be        = 4'hF;
                misalign  = (addr_lo != 2'b00);
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores over a req/ack port and produces
// a one-cycle writeback beat per accepted operation.
//
// state | meaning
// IDLE  | no operation in flight, run accepted
// REQ   | memory transaction outstanding, dmem_* held until ack, run ignored
// DONE  | writeback beat presented this cycle, run accepted
module mem_access
    import mspu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [31:0]       alu_result,
    input  logic              mem_to_reg,
    input  logic [1:0]        bytes,
    input  logic              load_unsigned,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    input  logic [4:0]        rd,
    input  logic              reg_we,
    output logic              busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    output logic [31:0]       wb_data,
    output logic              misalign_err
);

    mem_state_e        state_q, state_d;
    logic [1:0]        addr_lo_q;
    logic [1:0]        bytes_q;
    logic              unsigned_q;
    logic              mem_to_reg_q;
    logic              reg_we_q;
    logic              dmem_req_q, dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [3:0]        dmem_be_q;
    logic [31:0]       dmem_wdata_q;
    logic              wb_valid_q, wb_we_q, misalign_err_q;
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_data_q;

    logic              in_req, accept, mem_op, mis_op;
    logic [1:0]        al_addr_lo, al_bytes;
    logic              al_unsigned;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_load;
    logic              al_misalign;

    assign in_req = (state_q == REQ);
    assign accept = run && !in_req;
    assign mem_op = we || re;
    assign mis_op = mem_op && al_misalign;

    // While a transaction is outstanding the aligner works on the captured
    // access so the returning word is steered by the original address/size.
    assign al_addr_lo  = in_req ? addr_lo_q  : alu_result[1:0];
    assign al_bytes    = in_req ? bytes_q    : bytes;
    assign al_unsigned = in_req ? unsigned_q : load_unsigned;

    lsu_align u_align (
        .addr_lo       (al_addr_lo),
        .bytes         (al_bytes),
        .load_unsigned (al_unsigned),
        .wdata         (wdata),
        .rdata         (dmem_rdata),
        .be            (al_be),
        .wdata_rep     (al_wdata),
        .load_data     (al_load),
        .misalign      (al_misalign)
    );

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     state_d = dmem_ack ? DONE : REQ;
            default: begin
                if (run) state_d = (mem_op && !al_misalign) ? REQ : DONE;
                else     state_d = IDLE;
            end
        endcase
    end

    // State, captured operation and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_lo_q      <= 2'b00;
            bytes_q        <= 2'b00;
            unsigned_q     <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            reg_we_q       <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_be_q      <= 4'h0;
            dmem_wdata_q   <= 32'h0;
            wb_valid_q     <= 1'b0;
            wb_we_q        <= 1'b0;
            misalign_err_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'h0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= (state_d == REQ);
            wb_valid_q     <= (state_d == DONE);
            wb_we_q        <= 1'b0;
            misalign_err_q <= 1'b0;
            if (accept) begin
                addr_lo_q    <= alu_result[1:0];
                bytes_q      <= bytes;
                unsigned_q   <= load_unsigned;
                mem_to_reg_q <= mem_to_reg;
                reg_we_q     <= reg_we;
                wb_rd_q      <= rd;
                wb_data_q    <= alu_result;
                if (mem_op && !al_misalign) begin
                    dmem_we_q    <= we;
                    dmem_addr_q  <= alu_result[ADDR_W-1:0] & ~ADDR_W'(3);
                    dmem_be_q    <= al_be;
                    dmem_wdata_q <= al_wdata;
                end else begin
                    wb_we_q        <= reg_we && !mis_op;
                    misalign_err_q <= mis_op;
                end
            end else if (in_req && dmem_ack) begin
                wb_we_q <= reg_we_q;
                if (mem_to_reg_q) wb_data_q <= al_load;
            end
        end
    end

    assign busy         = in_req;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_we        = wb_we_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: non-memory ops, stores, loads with extension,
// misalignment, zero-wait back-to-back issue and reset during a transaction.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset, run, mem_to_reg, load_unsigned, we, re, reg_we;
    logic [31:0] alu_result, wdata, dmem_rdata;
    logic [1:0]  bytes;
    logic [4:0]  rd;
    logic        dmem_ack;
    logic        busy, dmem_req, dmem_we, wb_valid, wb_we, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .alu_result    (alu_result),
        .mem_to_reg    (mem_to_reg),
        .bytes         (bytes),
        .load_unsigned (load_unsigned),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rd            (rd),
        .reg_we        (reg_we),
        .busy          (busy),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_we         (wb_we),
        .wb_data       (wb_data),
        .misalign_err  (misalign_err)
    );

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run = 0; alu_result = 0; mem_to_reg = 0; bytes = 2'd2; load_unsigned = 0;
        wdata = 0; we = 0; re = 0; rd = 0; reg_we = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        checks++; if ({dmem_addr, dmem_wdata, wb_data} !== 96'h0) begin errors++; $display("FAIL reset_data got=%h %h %h exp=0", dmem_addr, dmem_wdata, wb_data); end
        checks++; if ({dmem_be, wb_rd, wb_we, misalign_err, dmem_we} !== 12'h0) begin errors++; $display("FAIL reset_ctrl got=%h %h %b %b %b exp=0", dmem_be, wb_rd, wb_we, misalign_err, dmem_we); end
    endtask

    task automatic test_non_mem();
        clear_inputs();
        run = 1; alu_result = 32'h1234; reg_we = 1; rd = 5'd5;
        step();
        run = 0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL nonmem_data got=%h exp=00001234", wb_data); end
        checks++; if (wb_rd !== 5'd5 || wb_we !== 1'b1) begin errors++; $display("FAIL nonmem_rd_we got=%0d/%b exp=5/1", wb_rd, wb_we); end
        checks++; if (dmem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nonmem_req got=%b/%b exp=0/0", dmem_req, busy); end
        step();
        checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_after got=%b/%b exp=0/0", wb_valid, dmem_req); end
    endtask

    task automatic test_byte_store();
        clear_inputs();
        run = 1; bytes = 2'd0; alu_result = 32'h103; wdata = 32'hAB; we = 1; rd = 5'd9;
        step();
        clear_inputs();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL st_req got=%b/%b exp=1/1", dmem_req, dmem_we); end
        checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL st_addr got=%h exp=00000100", dmem_addr); end
        checks++; if (dmem_be !== 4'h8) begin errors++; $display("FAIL st_be got=%h exp=8", dmem_be); end
        checks++; if (dmem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL st_wdata got=%h exp=abababab", dmem_wdata); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL st_busy_%0d got=%b/%b exp=1/1", i, busy, dmem_req); end
            checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'h8 || dmem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL st_hold_%0d got=%h %h %h", i, dmem_addr, dmem_be, dmem_wdata); end
            // run during REQ must be ignored
            run = (i == 0); alu_result = 32'h999;
            dmem_ack = (i == 2);
            step();
        end
        clear_inputs();
        checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL st_done got=%b/%b/%b exp=1/0/0", wb_valid, wb_we, busy); end
        checks++; if (wb_data !== 32'h103 || wb_rd !== 5'd9) begin errors++; $display("FAIL st_wb got=%h/%0d exp=00000103/9", wb_data, wb_rd); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL st_req_drop got=%b exp=0", dmem_req); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL st_one_beat got=%b exp=0", wb_valid); end
    endtask

    task automatic test_half_load(input logic uns, input logic [31:0] exp);
        clear_inputs();
        run = 1; bytes = 2'd1; alu_result = 32'h202; re = 1; mem_to_reg = 1;
        reg_we = 1; rd = 5'd7; load_unsigned = uns;
        step();
        clear_inputs();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'hC || dmem_addr !== 32'h200) begin errors++; $display("FAIL ld_req_u%0d got=%b %b %h %h exp=1 0 c 00000200", uns, dmem_req, dmem_we, dmem_be, dmem_addr); end
        dmem_ack = 1; dmem_rdata = 32'h8001_0000;
        step();
        clear_inputs();
        checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL ld_beat_u%0d got=%b/%b/%0d exp=1/1/7", uns, wb_valid, wb_we, wb_rd); end
        checks++; if (wb_data !== exp) begin errors++; $display("FAIL ld_data_u%0d got=%h exp=%h", uns, wb_data, exp); end
        step();
    endtask

    task automatic test_misalign();
        clear_inputs();
        run = 1; bytes = 2'd2; alu_result = 32'h301; re = 1; mem_to_reg = 1; reg_we = 1; rd = 5'd4;
        step();
        clear_inputs();
        checks++; if (dmem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mis_req got=%b/%b exp=0/0", dmem_req, busy); end
        checks++; if (wb_valid !== 1'b1 || misalign_err !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL mis_beat got=%b/%b/%b exp=1/1/0", wb_valid, misalign_err, wb_we); end
        step();
        checks++; if (misalign_err !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL mis_after got=%b/%b/%b exp=0/0/0", misalign_err, wb_valid, dmem_req); end
        // illegal size 3 at an aligned address is also an error
        run = 1; bytes = 2'd3; alu_result = 32'h400; we = 1;
        step();
        clear_inputs();
        checks++; if (misalign_err !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL mis_size3 got=%b/%b exp=1/0", misalign_err, dmem_req); end
        step();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        run = 1; bytes = 2'd0; alu_result = 32'h001; re = 1; mem_to_reg = 1;
        load_unsigned = 1; reg_we = 1; rd = 5'd2;
        step();
        clear_inputs();
        dmem_ack = 1; dmem_rdata = 32'h0000_5A00;
        checks++; if (dmem_req !== 1'b1 || dmem_be !== 4'h2) begin errors++; $display("FAIL b2b_req got=%b/%h exp=1/2", dmem_req, dmem_be); end
        step();
        clear_inputs();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h5A) begin errors++; $display("FAIL b2b_ld got=%b/%h exp=1/0000005a", wb_valid, wb_data); end
        run = 1; alu_result = 32'h77; reg_we = 1; rd = 5'd3;
        step();
        run = 1; alu_result = 32'h88; reg_we = 0; rd = 5'd6;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h77 || wb_rd !== 5'd3 || wb_we !== 1'b1) begin errors++; $display("FAIL b2b_op2 got=%b/%h/%0d/%b exp=1/00000077/3/1", wb_valid, wb_data, wb_rd, wb_we); end
        step();
        clear_inputs();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h88 || wb_rd !== 5'd6 || wb_we !== 1'b0) begin errors++; $display("FAIL b2b_op3 got=%b/%h/%0d/%b exp=1/00000088/6/0", wb_valid, wb_data, wb_rd, wb_we); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", wb_valid); end
    endtask

    task automatic test_reset_mid_req();
        clear_inputs();
        run = 1; bytes = 2'd2; alu_result = 32'h400; wdata = 32'hDEADBEEF; we = 1;
        step();
        clear_inputs();
        checks++; if (dmem_req !== 1'b1 || dmem_be !== 4'hF || dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_req got=%b/%h/%h exp=1/f/deadbeef", dmem_req, dmem_be, dmem_wdata); end
        reset = 1;
        step();
        reset = 0; dmem_ack = 1;
        checks++; if (dmem_req !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_drop got=%b/%b/%b exp=0/0/0", dmem_req, busy, wb_valid); end
        step();
        dmem_ack = 0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rst_stray_ack got=%b/%b/%b exp=0/0/0", wb_valid, busy, dmem_req); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_no_beat got=%b exp=0", wb_valid); end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_non_mem();
        test_byte_store();
        test_half_load(1'b0, 32'hFFFF8001);
        test_half_load(1'b1, 32'h00008001);
        test_misalign();
        test_back_to_back();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
